dcache_mshr_ctrl: RTL and testbench
===================================

Name: dcache_mshr_ctrl

Overview:
- Non-blocking DCache miss controller.
- Tracks up to NUM_MSHR outstanding block misses from the LSQ in miss-status holding registers (MSHRs).
- Merges repeat misses to the same block, and issues and retries BUS_LOAD requests to data memory, including when a request is rejected for ICache priority.
- Matches returning memory tags to entries and drives one-cycle fill writes into DCache memory together with an LSQ wakeup.
- Sits between the LSQ/DCache hit logic and the shared memory arbiter. It replaces the single-outstanding-miss controller.

Parameters:
- NUM_MSHR, 4, number of MSHR entries (≥2, power of two).
- MEM_TAG_W, 4, memory tag width; tag 0 means no response/rejected.
- BLK_OFF, 3, block offset bits (8-byte blocks).
- ADDR_W, 16, used address bits stored per entry.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- req_valid  in  1  LSQ presents a request that missed in DCache this cycle
- req_is_store  in  1  request is a store
- req_addr  in  XLEN  byte address of request
- req_ready  out  1  request accepted (allocated or merged) this cycle
- reject_D_req  in  1  arbiter gives ICache priority this cycle
- Dmem2Dctrl_response  in  MEM_TAG_W  tag assigned to the issued request; 0 = not accepted
- Dmem2Dctrl_tag  in  MEM_TAG_W  tag of data returning this cycle; 0 = none
- Dmem2Dctrl_data  in  64  returning block data
- Dctrl2Dmem_command  out  BUS_COMMAND  BUS_LOAD or BUS_NONE
- Dctrl2Dmem_addr  out  XLEN  block-aligned address (low BLK_OFF bits zero)
- fill_valid  out  1  write fill_data into DCache memory; also LSQ replay wakeup
- fill_addr  out  ADDR_W  block address of fill (low BLK_OFF bits zero)
- fill_data  out  64  block data
- fill_store_merged  out  1  at least one store merged into this entry; LSQ replays stores
- mshr_full  out  1  no INVALID entry
- mshr_count  out  $clog2(NUM_MSHR)+1  number of non-INVALID entries

Behaviour:
- Per-entry state is INVALID, PENDING or ISSUED. Each entry also holds blk_addr[ADDR_W-1:BLK_OFF], mem_tag and store_merged.
- Reset (reset==0, asynchronous):
  - All entries become INVALID and the round-robin pointer rr_ptr becomes 0.
  - fill_valid=0, fill_addr=0, fill_data=0, fill_store_merged=0, mshr_count=0, mshr_full=0.
  - Dctrl2Dmem_command=BUS_NONE and Dctrl2Dmem_addr=0, since no entry is PENDING.
  - req_ready=1.
  - Memory tags returning after reset match no entry and are ignored.
- Request acceptance (combinational req_ready, independent of req_valid):
  - Match: a non-INVALID entry with equal block address exists → merge. store_merged |= req_is_store. req_ready=1. No allocation.
  - Exception to match: the matching entry is being filled this cycle → req_ready=0. The LSQ retries and will hit.
  - No match, an INVALID entry exists → allocate the lowest-index INVALID entry as PENDING, with store_merged=req_is_store. req_ready=1.
  - No match, no INVALID entry → req_ready=0. State is unchanged.
  - An entry freed this cycle is not allocatable until the next cycle.
- Issue:
  - The candidate is the first PENDING entry at or after rr_ptr, searching cyclically.
  - With a candidate: Dctrl2Dmem_command=BUS_LOAD and Dctrl2Dmem_addr={blk_addr, BLK_OFF zeros}. Otherwise BUS_NONE, addr 0.
  - An entry allocated this cycle is not a candidate until the next cycle.
  - Issue succeeds when reject_D_req==0 and Dmem2Dctrl_response!=0. On success, at the edge: the entry goes to ISSUED, mem_tag=response, rr_ptr=(idx+1) mod NUM_MSHR.
  - On rejection or response 0: the entry stays PENDING and is retried next cycle; rr_ptr is unchanged.
  - At most one issue per cycle.
- Fill:
  - Dmem2Dctrl_tag!=0 matching an ISSUED entry's mem_tag triggers a fill.
  - Next cycle: fill_valid=1 for exactly one cycle, with fill_addr, fill_data (registered Dmem2Dctrl_data) and fill_store_merged from that entry.
  - The entry becomes INVALID at the same edge.
  - A tag matching no ISSUED entry is ignored.
  - An issue success and a fill for different entries in the same cycle are both performed.
- mshr_count and mshr_full are registered from next-state and track all allocate/free events in the same edge.
- Merge into a PENDING entry never creates a second memory request.

Test Plan:
- Single miss:
  - Stimulus: req 0x0104 load; response 3 next cycle; tag 3 with data 0xDEADBEEF_CAFEF00D four cycles later.
  - Required: Dctrl2Dmem_addr=0x0100 with BUS_LOAD one cycle after allocation; fill_valid one cycle after the tag, fill_addr=0x0100, fill_store_merged=0; mshr_count 1→0.
- Merge:
  - Stimulus: loads 0x0200 then store 0x0204 before the fill.
  - Required: exactly one BUS_LOAD (addr 0x0200); second req_ready=1; fill_store_merged=1.
- Full:
  - Stimulus: 4 misses to distinct blocks, with all responses held 0, then a 5th miss.
  - Required: mshr_full=1, 5th req_ready=0; after a tag returns for one entry, the 5th is accepted 1 cycle after the freeing edge.
- Reject/retry:
  - Stimulus: reject_D_req=1 for 3 cycles with the response nonzero.
  - Required: BUS_LOAD held for the same address throughout; entry ISSUED only on the first cycle with reject=0 and response=5.
- Out-of-order fills and round robin:
  - Stimulus: entries given tags 1,2,3; tags returned in order 3,1,2.
  - Required: fills in order 3,1,2 with the correct addresses; issue order follows rr_ptr.
- Reset mid-operation:
  - Stimulus: assert reset with 2 ISSUED entries; release; return their old tags.
  - Required: no fill_valid; mshr_count=0; req_ready=1.

Source files
------------

// File: rtl/dcache_mshr_ctrl_if.sv
// LSQ request, memory bus and fill signals of the DCache miss controller.
// The controller uses the slave modport; the LSQ/memory side uses master.
interface dcache_mshr_ctrl_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MEM_TAG_W = 4,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned NUM_MSHR  = 4,
    parameter int unsigned CMD_W     = 2
);
    localparam int unsigned CNT_W = $clog2(NUM_MSHR) + 1;

    // LSQ request side
    logic                 req_valid;
    logic                 req_is_store;
    logic [XLEN-1:0]      req_addr;
    logic                 req_ready;

    // Memory arbiter side
    logic                 reject_D_req;
    logic [MEM_TAG_W-1:0] Dmem2Dctrl_response;
    logic [MEM_TAG_W-1:0] Dmem2Dctrl_tag;
    logic [63:0]          Dmem2Dctrl_data;
    logic [CMD_W-1:0]     Dctrl2Dmem_command;
    logic [XLEN-1:0]      Dctrl2Dmem_addr;

    // DCache fill / LSQ wakeup side
    logic                 fill_valid;
    logic [ADDR_W-1:0]    fill_addr;
    logic [63:0]          fill_data;
    logic                 fill_store_merged;
    logic                 mshr_full;
    logic [CNT_W-1:0]     mshr_count;

    modport slave (
        input  req_valid, req_is_store, req_addr,
        input  reject_D_req, Dmem2Dctrl_response, Dmem2Dctrl_tag, Dmem2Dctrl_data,
        output req_ready, Dctrl2Dmem_command, Dctrl2Dmem_addr,
        output fill_valid, fill_addr, fill_data, fill_store_merged, mshr_full, mshr_count
    );

    modport master (
        output req_valid, req_is_store, req_addr,
        output reject_D_req, Dmem2Dctrl_response, Dmem2Dctrl_tag, Dmem2Dctrl_data,
        input  req_ready, Dctrl2Dmem_command, Dctrl2Dmem_addr,
        input  fill_valid, fill_addr, fill_data, fill_store_merged, mshr_full, mshr_count
    );
endinterface

// File: rtl/dcache_mshr_ctrl.sv
// Non-blocking DCache miss controller: NUM_MSHR miss-status holding registers
// with same-block merging, round-robin BUS_LOAD issue with retry, and
// tag-matched one-cycle fill writes that double as LSQ wakeups.
module dcache_mshr_ctrl #(
    parameter int unsigned NUM_MSHR  = 4,
    parameter int unsigned MEM_TAG_W = 4,
    parameter int unsigned BLK_OFF   = 3,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned XLEN      = 32
) (
    input logic               clock,
    input logic               reset,
    dcache_mshr_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_MSHR);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned BLK_W = ADDR_W - BLK_OFF;

    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    typedef enum logic [1:0] {
        StInvalid,
        StPending,
        StIssued
    } mshr_state_e;

    // Per-entry state
    mshr_state_e          r_state  [NUM_MSHR];
    logic [BLK_W-1:0]     r_blk    [NUM_MSHR];
    logic [MEM_TAG_W-1:0] r_tag    [NUM_MSHR];
    logic                 r_sm     [NUM_MSHR];
    logic [IDX_W-1:0]     r_rr_ptr;

    mshr_state_e          w_state_nxt [NUM_MSHR];
    logic [BLK_W-1:0]     w_blk_nxt   [NUM_MSHR];
    logic [MEM_TAG_W-1:0] w_tag_nxt   [NUM_MSHR];
    logic                 w_sm_nxt    [NUM_MSHR];
    logic [IDX_W-1:0]     w_rr_nxt;

    // Fill outputs and occupancy
    logic                 r_fill_valid;
    logic [ADDR_W-1:0]    r_fill_addr;
    logic [63:0]          r_fill_data;
    logic                 r_fill_sm;
    logic [CNT_W-1:0]     r_count;
    logic                 r_full;
    logic [CNT_W-1:0]     w_count_nxt;
    logic                 w_full_nxt;

    // Lookup results
    logic [BLK_W-1:0]     w_req_blk;
    logic                 w_fill_hit;
    logic [IDX_W-1:0]     w_fill_idx;
    logic                 w_match_hit;
    logic [IDX_W-1:0]     w_match_idx;
    logic                 w_free_hit;
    logic [IDX_W-1:0]     w_free_idx;
    logic                 w_cand_hit;
    logic [IDX_W-1:0]     w_cand_idx;
    logic [IDX_W-1:0]     w_scan;
    logic                 w_req_ready;
    logic                 w_accept;
    logic                 w_issue_ok;
    logic                 w_unused_addr;

    assign w_req_blk     = bus.req_addr[ADDR_W-1:BLK_OFF];
    assign w_unused_addr = ^{bus.req_addr[XLEN-1:ADDR_W], bus.req_addr[BLK_OFF-1:0]};

    // Associative lookups: fill tag, request block, lowest free entry
    always_comb begin
        w_fill_hit  = 1'b0;
        w_fill_idx  = '0;
        w_match_hit = 1'b0;
        w_match_idx = '0;
        w_free_hit  = 1'b0;
        w_free_idx  = '0;
        // Descending scan so the lowest index wins
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (r_state[i] == StIssued && bus.Dmem2Dctrl_tag != '0 &&
                bus.Dmem2Dctrl_tag == r_tag[i]) begin
                w_fill_hit = 1'b1;
                w_fill_idx = IDX_W'(i);
            end
            if (r_state[i] != StInvalid && r_blk[i] == w_req_blk) begin
                w_match_hit = 1'b1;
                w_match_idx = IDX_W'(i);
            end
            if (r_state[i] == StInvalid) begin
                w_free_hit = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    // Issue candidate: first PENDING entry at or after rr_ptr, cyclically
    always_comb begin
        w_cand_hit = 1'b0;
        w_cand_idx = '0;
        w_scan     = '0;
        for (int k = NUM_MSHR - 1; k >= 0; k--) begin
            w_scan = r_rr_ptr + IDX_W'(k);
            if (r_state[w_scan] == StPending) begin
                w_cand_hit = 1'b1;
                w_cand_idx = w_scan;
            end
        end
    end

    // Acceptance and issue decisions, plus bus request outputs
    always_comb begin
        // A merge into the entry being filled is refused; the LSQ retries and hits
        if (w_match_hit) begin
            w_req_ready = !(w_fill_hit && w_fill_idx == w_match_idx);
        end else begin
            w_req_ready = w_free_hit;
        end
        w_accept   = bus.req_valid && w_req_ready;
        w_issue_ok = w_cand_hit && !bus.reject_D_req && bus.Dmem2Dctrl_response != '0;
        bus.Dctrl2Dmem_command = BUS_NONE;
        bus.Dctrl2Dmem_addr    = '0;
        if (w_cand_hit) begin
            bus.Dctrl2Dmem_command = BUS_LOAD;
            bus.Dctrl2Dmem_addr    = XLEN'({r_blk[w_cand_idx], {BLK_OFF{1'b0}}});
        end
    end

    // Next-state of entries and round-robin pointer
    always_comb begin
        for (int i = 0; i < NUM_MSHR; i++) begin
            w_state_nxt[i] = r_state[i];
            w_blk_nxt[i]   = r_blk[i];
            w_tag_nxt[i]   = r_tag[i];
            w_sm_nxt[i]    = r_sm[i];
        end
        w_rr_nxt = r_rr_ptr;
        if (w_issue_ok) begin
            w_state_nxt[w_cand_idx] = StIssued;
            w_tag_nxt[w_cand_idx]   = bus.Dmem2Dctrl_response;
            w_rr_nxt                = w_cand_idx + IDX_W'(1);
        end
        if (w_fill_hit) begin
            w_state_nxt[w_fill_idx] = StInvalid;
        end
        // Allocation only targets an entry INVALID now, so it never collides with issue/fill
        if (w_accept) begin
            if (w_match_hit) begin
                w_sm_nxt[w_match_idx] = r_sm[w_match_idx] | bus.req_is_store;
            end else begin
                w_state_nxt[w_free_idx] = StPending;
                w_blk_nxt[w_free_idx]   = w_req_blk;
                w_tag_nxt[w_free_idx]   = '0;
                w_sm_nxt[w_free_idx]    = bus.req_is_store;
            end
        end
    end

    // Occupancy derived from next state so it tracks the same edge
    always_comb begin
        w_count_nxt = '0;
        for (int i = 0; i < NUM_MSHR; i++) begin
            if (w_state_nxt[i] != StInvalid) begin
                w_count_nxt = w_count_nxt + CNT_W'(1);
            end
        end
        w_full_nxt = (w_count_nxt == CNT_W'(NUM_MSHR));
    end

    // State registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                r_state[i] <= StInvalid;
                r_blk[i]   <= '0;
                r_tag[i]   <= '0;
                r_sm[i]    <= 1'b0;
            end
            r_rr_ptr     <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_fill_valid <= 1'b0;
            r_fill_addr  <= '0;
            r_fill_data  <= '0;
            r_fill_sm    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_blk[i]   <= w_blk_nxt[i];
                r_tag[i]   <= w_tag_nxt[i];
                r_sm[i]    <= w_sm_nxt[i];
            end
            r_rr_ptr     <= w_rr_nxt;
            r_count      <= w_count_nxt;
            r_full       <= w_full_nxt;
            r_fill_valid <= w_fill_hit;
            if (w_fill_hit) begin
                r_fill_addr <= {r_blk[w_fill_idx], {BLK_OFF{1'b0}}};
                r_fill_data <= bus.Dmem2Dctrl_data;
                r_fill_sm   <= r_sm[w_fill_idx];
            end
        end
    end

    assign bus.req_ready         = w_req_ready;
    assign bus.fill_valid        = r_fill_valid;
    assign bus.fill_addr         = r_fill_addr;
    assign bus.fill_data         = r_fill_data;
    assign bus.fill_store_merged = r_fill_sm;
    assign bus.mshr_count        = r_count;
    assign bus.mshr_full         = r_full;
endmodule

// File: tb/tb_dcache_mshr_ctrl.sv
// Directed bench for dcache_mshr_ctrl: single miss, merge, full, reset
// mid-operation, reject/retry and out-of-order fills with round robin.
module tb_dcache_mshr_ctrl;
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_pass;

    dcache_mshr_ctrl_if #(
        .XLEN      (32),
        .MEM_TAG_W (4),
        .ADDR_W    (16),
        .NUM_MSHR  (4),
        .CMD_W     (2)
    ) bus ();

    dcache_mshr_ctrl #(
        .NUM_MSHR  (4),
        .MEM_TAG_W (4),
        .BLK_OFF   (3),
        .ADDR_W    (16),
        .XLEN      (32)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic req(input logic [31:0] addr, input logic store);
        bus.req_valid    = 1'b1;
        bus.req_addr     = addr;
        bus.req_is_store = store;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b0;
        bus.req_valid           = 1'b0;
        bus.req_is_store        = 1'b0;
        bus.req_addr            = '0;
        bus.reject_D_req        = 1'b0;
        bus.Dmem2Dctrl_response = '0;
        bus.Dmem2Dctrl_tag      = '0;
        bus.Dmem2Dctrl_data     = '0;
        #2;
        check("rst_ready", bus.req_ready, 1);
        check("rst_cmd", bus.Dctrl2Dmem_command, BUS_NONE);
        check("rst_addr", bus.Dctrl2Dmem_addr, 0);
        check("rst_fill_valid", bus.fill_valid, 0);
        check("rst_count", bus.mshr_count, 0);
        check("rst_full", bus.mshr_full, 0);
        tick();
        reset = 1'b1;

        // Single miss
        req(32'h0104, 1'b0);
        #1;
        check("t1_ready", bus.req_ready, 1);
        check("t1_cmd_before", bus.Dctrl2Dmem_command, BUS_NONE);
        tick();
        bus.req_valid = 1'b0;
        #1;
        check("t1_count1", bus.mshr_count, 1);
        check("t1_cmd", bus.Dctrl2Dmem_command, BUS_LOAD);
        check("t1_addr", bus.Dctrl2Dmem_addr, 32'h0100);
        bus.Dmem2Dctrl_response = 4'd3;
        tick();
        bus.Dmem2Dctrl_response = 4'd0;
        #1;
        check("t1_cmd_after", bus.Dctrl2Dmem_command, BUS_NONE);
        repeat (3) tick();
        bus.Dmem2Dctrl_tag  = 4'd3;
        bus.Dmem2Dctrl_data = 64'hDEADBEEF_CAFEF00D;
        #1;
        check("t1_no_fill_yet", bus.fill_valid, 0);
        tick();
        bus.Dmem2Dctrl_tag = 4'd0;
        #1;
        check("t1_fill_valid", bus.fill_valid, 1);
        check("t1_fill_addr", bus.fill_addr, 16'h0100);
        check("t1_fill_data", bus.fill_data, 64'hDEADBEEF_CAFEF00D);
        check("t1_fill_sm", bus.fill_store_merged, 0);
        check("t1_count0", bus.mshr_count, 0);
        tick();
        check("t1_fill_once", bus.fill_valid, 0);

        // Merge: load 0x0200 then store 0x0204
        req(32'h0200, 1'b0);
        #1;
        check("t2_ready1", bus.req_ready, 1);
        tick();
        req(32'h0204, 1'b1);
        #1;
        check("t2_ready2", bus.req_ready, 1);
        check("t2_cmd", bus.Dctrl2Dmem_command, BUS_LOAD);
        check("t2_addr", bus.Dctrl2Dmem_addr, 32'h0200);
        tick();
        bus.req_valid = 1'b0;
        bus.Dmem2Dctrl_response = 4'd4;
        #1;
        check("t2_count", bus.mshr_count, 1);
        check("t2_cmd_issue", bus.Dctrl2Dmem_command, BUS_LOAD);
        check("t2_addr_issue", bus.Dctrl2Dmem_addr, 32'h0200);
        tick();
        bus.Dmem2Dctrl_response = 4'd0;
        #1;
        check("t2_single_load", bus.Dctrl2Dmem_command, BUS_NONE);
        tick();
        bus.Dmem2Dctrl_tag  = 4'd4;
        bus.Dmem2Dctrl_data = 64'h1111_2222_3333_4444;
        tick();
        bus.Dmem2Dctrl_tag = 4'd0;
        #1;
        check("t2_fill_valid", bus.fill_valid, 1);
        check("t2_fill_addr", bus.fill_addr, 16'h0200);
        check("t2_fill_sm", bus.fill_store_merged, 1);

        // Full: four distinct blocks, responses held 0
        for (int i = 0; i < 4; i++) begin
            req(32'h1000 + 32'(8 * i), 1'b0);
            #1;
            check("t3_alloc_ready", bus.req_ready, 1);
            tick();
        end
        bus.req_valid = 1'b0;
        #1;
        check("t3_count4", bus.mshr_count, 4);
        check("t3_full", bus.mshr_full, 1);
        req(32'h2000, 1'b0);
        #1;
        check("t3_fifth_rejected", bus.req_ready, 0);
        // rr_ptr is 1 after the previous issue of entry 0
        check("t3_rr_addr", bus.Dctrl2Dmem_addr, 32'h1008);
        bus.Dmem2Dctrl_response = 4'd7;
        tick();
        bus.Dmem2Dctrl_response = 4'd0;
        bus.Dmem2Dctrl_tag      = 4'd7;
        bus.Dmem2Dctrl_data     = 64'h5;
        #1;
        check("t3_not_yet_free", bus.req_ready, 0);
        tick();
        bus.Dmem2Dctrl_tag = 4'd0;
        #1;
        check("t3_fill_valid", bus.fill_valid, 1);
        check("t3_fill_addr", bus.fill_addr, 16'h1008);
        check("t3_fifth_accepted", bus.req_ready, 1);
        check("t3_count3", bus.mshr_count, 3);
        check("t3_not_full", bus.mshr_full, 0);
        tick();
        bus.req_valid = 1'b0;
        #1;
        check("t3_count4_again", bus.mshr_count, 4);
        check("t3_full_again", bus.mshr_full, 1);

        // Reset with two ISSUED entries (tags 8 and 9)
        check("t4_issue_a", bus.Dctrl2Dmem_addr, 32'h1010);
        bus.Dmem2Dctrl_response = 4'd8;
        tick();
        #1;
        check("t4_issue_b", bus.Dctrl2Dmem_addr, 32'h1018);
        bus.Dmem2Dctrl_response = 4'd9;
        tick();
        bus.Dmem2Dctrl_response = 4'd0;
        #1;
        check("t4_rr_wrap", bus.Dctrl2Dmem_addr, 32'h1000);
        reset = 1'b0;
        #1;
        check("t4_count", bus.mshr_count, 0);
        check("t4_full", bus.mshr_full, 0);
        check("t4_ready", bus.req_ready, 1);
        check("t4_cmd", bus.Dctrl2Dmem_command, BUS_NONE);
        tick();
        reset = 1'b1;
        bus.Dmem2Dctrl_tag = 4'd8;
        tick();
        bus.Dmem2Dctrl_tag = 4'd9;
        #1;
        check("t4_stale_tag8", bus.fill_valid, 0);
        tick();
        bus.Dmem2Dctrl_tag = 4'd0;
        #1;
        check("t4_stale_tag9", bus.fill_valid, 0);
        check("t4_count_after", bus.mshr_count, 0);

        // Reject/retry
        req(32'h0300, 1'b0);
        tick();
        bus.req_valid           = 1'b0;
        bus.reject_D_req        = 1'b1;
        bus.Dmem2Dctrl_response = 4'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_held_cmd", bus.Dctrl2Dmem_command, BUS_LOAD);
            check("t5_held_addr", bus.Dctrl2Dmem_addr, 32'h0300);
            tick();
        end
        bus.reject_D_req = 1'b0;
        #1;
        check("t5_final_cmd", bus.Dctrl2Dmem_command, BUS_LOAD);
        check("t5_final_addr", bus.Dctrl2Dmem_addr, 32'h0300);
        tick();
        bus.Dmem2Dctrl_response = 4'd0;
        #1;
        check("t5_issued", bus.Dctrl2Dmem_command, BUS_NONE);
        check("t5_count", bus.mshr_count, 1);
        bus.Dmem2Dctrl_tag = 4'd5;
        tick();
        bus.Dmem2Dctrl_tag = 4'd0;
        #1;
        check("t5_fill_valid", bus.fill_valid, 1);
        check("t5_fill_addr", bus.fill_addr, 16'h0300);

        // Out-of-order fills; rr_ptr is 1 here
        for (int i = 0; i < 3; i++) begin
            req(32'h0400 + 32'(8 * i), 1'b0);
            tick();
        end
        bus.req_valid = 1'b0;
        #1;
        check("t6_rr_first", bus.Dctrl2Dmem_addr, 32'h0408);
        bus.Dmem2Dctrl_response = 4'd1;
        tick();
        #1;
        check("t6_rr_second", bus.Dctrl2Dmem_addr, 32'h0410);
        bus.Dmem2Dctrl_response = 4'd2;
        tick();
        #1;
        check("t6_rr_third", bus.Dctrl2Dmem_addr, 32'h0400);
        bus.Dmem2Dctrl_response = 4'd3;
        tick();
        bus.Dmem2Dctrl_response = 4'd0;
        #1;
        check("t6_all_issued", bus.Dctrl2Dmem_command, BUS_NONE);
        bus.Dmem2Dctrl_tag  = 4'd3;
        bus.Dmem2Dctrl_data = 64'hAAAA;
        tick();
        bus.Dmem2Dctrl_tag  = 4'd1;
        bus.Dmem2Dctrl_data = 64'hBBBB;
        #1;
        check("t6_fill3_valid", bus.fill_valid, 1);
        check("t6_fill3_addr", bus.fill_addr, 16'h0400);
        check("t6_fill3_data", bus.fill_data, 64'hAAAA);
        tick();
        bus.Dmem2Dctrl_tag  = 4'd2;
        bus.Dmem2Dctrl_data = 64'hCCCC;
        #1;
        check("t6_fill1_valid", bus.fill_valid, 1);
        check("t6_fill1_addr", bus.fill_addr, 16'h0408);
        check("t6_fill1_data", bus.fill_data, 64'hBBBB);
        tick();
        bus.Dmem2Dctrl_tag = 4'd0;
        #1;
        check("t6_fill2_valid", bus.fill_valid, 1);
        check("t6_fill2_addr", bus.fill_addr, 16'h0410);
        check("t6_fill2_data", bus.fill_data, 64'hCCCC);
        check("t6_count0", bus.mshr_count, 0);
        tick();
        check("t6_fill_done", bus.fill_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
